cdu_dict_engine: RTL and testbench

- Parametrised, handshaked successor of the compression/decompression unit.
- Holds a dictionary of up to 2^IDX_W unique DATA_W-bit words.
- COMPRESS returns the word's index, inserting the word on a miss; DECOMPRESS returns the word stored at a given index.
- Sits between the command source and the response consumer, one command in flight at a time.

---
 rtl/cdu_dict_engine.sv | 153 +++++++++++++++
 tb/tb_cdu_dict_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdu_dict_engine.sv
// rtl/cdu_dict_engine.sv - handshaked dictionary compress/decompress engine
// Optional CLEAR command (opcode 11) enabled by defining CDU_DICT_CLEAR_EN.
module cdu_dict_engine #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        command,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IDX_W-1:0]  compressed_in,
  output logic              ready,
  output logic              resp_valid,
  output logic [1:0]        response,
  output logic [IDX_W-1:0]  compressed_out,
  output logic [DATA_W-1:0] decompressed_out,
  output logic [IDX_W:0]    fill_count,
  output logic              full
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, SEARCH, RESP} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   entry [DEPTH];
  logic [DATA_W-1:0]   key;
  logic [IDX_W:0]      ptr;
  logic [IDX_W:0]      fill_q;
  logic                full_q;

  logic                rsp_ld, cout_ld, dout_ld, insert, ptr_inc;
  logic [1:0]          rsp_nx;
  logic [IDX_W-1:0]    cout_nx;
  logic [DATA_W-1:0]   dout_nx;
`ifdef CDU_DICT_CLEAR_EN
  logic                clear_req;
`endif

  // fill_q never exceeds DEPTH, so its top bit alone flags a full dictionary
  assign full_q     = fill_q[IDX_W];
  assign full       = full_q;
  assign fill_count = fill_q;
  assign ready      = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rsp_ld   = 1'b0;
    rsp_nx   = 2'b00;
    cout_ld  = 1'b0;
    cout_nx  = '0;
    dout_ld  = 1'b0;
    dout_nx  = '0;
    insert   = 1'b0;
    ptr_inc  = 1'b0;
`ifdef CDU_DICT_CLEAR_EN
    clear_req = 1'b0;
`endif
    case (state)
      IDLE: begin
        case (command)
          2'b01: state_nx = SEARCH;
          2'b10: begin
            state_nx = RESP;
            rsp_ld   = 1'b1;
            dout_ld  = 1'b1;
            if ({1'b0, compressed_in} < fill_q) begin
              rsp_nx  = 2'b01;
              dout_nx = entry[compressed_in];
            end else begin
              rsp_nx  = 2'b11;
              cout_ld = 1'b1;
            end
          end
          2'b11: begin
            state_nx = RESP;
            rsp_ld   = 1'b1;
`ifdef CDU_DICT_CLEAR_EN
            rsp_nx    = 2'b10;
            clear_req = 1'b1;
`else
            rsp_nx  = 2'b11;
            cout_ld = 1'b1;
            dout_ld = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      SEARCH: begin
        // Linear scan: one entry per cycle, miss once ptr reaches fill level
        if (ptr == fill_q) begin
          state_nx = RESP;
          rsp_ld   = 1'b1;
          cout_ld  = 1'b1;
          if (full_q) begin
            rsp_nx  = 2'b11;
            dout_ld = 1'b1;
          end else begin
            insert  = 1'b1;
            cout_nx = fill_q[IDX_W-1:0];
          end
        end else if (entry[ptr[IDX_W-1:0]] == key) begin
          state_nx = RESP;
          rsp_ld   = 1'b1;
          cout_ld  = 1'b1;
          cout_nx  = ptr[IDX_W-1:0];
        end else begin
          ptr_inc = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr              <= '0;
      key              <= '0;
      fill_q           <= '0;
      response         <= 2'b00;
      compressed_out   <= '0;
      decompressed_out <= '0;
    end else begin
      if (state == IDLE && command == 2'b01) begin
        ptr <= '0;
        key <= data_in;
      end else if (ptr_inc) begin
        ptr <= ptr + (IDX_W+1)'(1);
      end
      if (insert) fill_q <= fill_q + (IDX_W+1)'(1);
`ifdef CDU_DICT_CLEAR_EN
      if (clear_req) fill_q <= '0;
`endif
      if (rsp_ld)  response         <= rsp_nx;
      if (cout_ld) compressed_out   <= cout_nx;
      if (dout_ld) decompressed_out <= dout_nx;
    end
  end

  // Entry storage carries no reset; stale words are hidden behind fill_q
  always_ff @(posedge clk) begin
    if (insert) entry[fill_q[IDX_W-1:0]] <= key;
  end

endmodule

// File: tb/tb_cdu_dict_engine.sv
// tb/tb_cdu_dict_engine.sv - scoreboard bench for cdu_dict_engine at IDX_W=2
module tb_cdu_dict_engine;

  typedef struct packed {
    logic [1:0]  resp;
    logic [1:0]  cout;
    logic [79:0] dout;
    logic [2:0]  fill;
    logic [7:0]  lat;
  } rsp_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [79:0] d;
    logic [1:0]  idx;
    rsp_t        e;
  } stim_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  command = 2'b00;
  logic [79:0] data_in = '0;
  logic [1:0]  compressed_in = '0;
  logic        ready, resp_valid, full;
  logic [1:0]  response, compressed_out;
  logic [79:0] decompressed_out;
  logic [2:0]  fill_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c0 = 0;
  logic timed_out;
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  localparam logic [79:0] WA = 80'h0000_1111_2222_3333_AAAA;
  localparam logic [79:0] WB = 80'h0000_4444_5555_6666_BBBB;
  localparam logic [79:0] WC = 80'h0000_7777_8888_9999_CCCC;
  localparam logic [79:0] WD = 80'hDDDD_0000_0000_0000_DDDD;
  localparam logic [79:0] WE = 80'hEEEE_0000_0000_0000_EEEE;

  cdu_dict_engine #(.DATA_W(80), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .command(command), .data_in(data_in),
    .compressed_in(compressed_in), .ready(ready), .resp_valid(resp_valid),
    .response(response), .compressed_out(compressed_out),
    .decompressed_out(decompressed_out), .fill_count(fill_count), .full(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (resp_valid)
      obs_q.push_back('{resp: response, cout: compressed_out, dout: decompressed_out,
                        fill: fill_count, lat: 8'(cyc - c0 + 1)});

  function automatic stim_t st(input logic [1:0] cmd, input logic [79:0] d, input logic [1:0] idx,
                               input logic [1:0] resp, input logic [1:0] cout, input logic [79:0] dout,
                               input logic [2:0] fill, input logic [7:0] lat);
    st = '{cmd: cmd, d: d, idx: idx,
           e: '{resp: resp, cout: cout, dout: dout, fill: fill, lat: lat}};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    command = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [1:0] cmd, input logic [79:0] d, input logic [1:0] idx);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    command = cmd;
    data_in = d;
    compressed_in = idx;
    @(posedge clk);
    #1;
    c0 = cyc;
    command = 2'b00;
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    timed_out = (obs_q.size() == 0);
  endtask

  task automatic test_reset();
    stim_t s;
    rsp_t  e, o;
    do_reset();
    #1;
    checks++;
    if ({ready, resp_valid, response, compressed_out, decompressed_out, fill_count, full}
        !== {1'b1, 1'b0, 2'b00, 2'b00, 80'h0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b resp=%0d cout=%0d dout=%h fill=%0d full=%b want rdy=1 vld=0 others 0",
               ready, resp_valid, response, compressed_out, decompressed_out, fill_count, full);
    end
    s = st(2'b01, 80'h1, 2'd0, 2'b00, 2'd0, 80'h0, 3'd1, 8'd2);
    exp_q.push_back(s.e);
    send(s.cmd, s.d, s.idx);
    checks++;
    e = exp_q.pop_front();
    if (timed_out) begin
      errors++;
      $display("FAIL reset_first_compress no response within bound");
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL reset_first_compress got resp=%0d cout=%0d dout=%h fill=%0d lat=%0d want resp=%0d cout=%0d dout=%h fill=%0d lat=%0d",
                 o.resp, o.cout, o.dout, o.fill, o.lat, e.resp, e.cout, e.dout, e.fill, e.lat);
      end
    end
  endtask

  task automatic test_dictionary();
    stim_t tbl[$];
    rsp_t  e, o;
    do_reset();
    tbl.push_back(st(2'b01, WA, 2'd0, 2'b00, 2'd0, 80'h0, 3'd1, 8'd2));
    tbl.push_back(st(2'b01, WB, 2'd0, 2'b00, 2'd1, 80'h0, 3'd2, 8'd3));
    tbl.push_back(st(2'b01, WC, 2'd0, 2'b00, 2'd2, 80'h0, 3'd3, 8'd4));
    tbl.push_back(st(2'b01, WB, 2'd0, 2'b00, 2'd1, 80'h0, 3'd3, 8'd3));
    tbl.push_back(st(2'b10, '0, 2'd2, 2'b01, 2'd1, WC,    3'd3, 8'd1));
    tbl.push_back(st(2'b10, '0, 2'd3, 2'b11, 2'd0, 80'h0, 3'd3, 8'd1));
    tbl.push_back(st(2'b01, WD, 2'd0, 2'b00, 2'd3, 80'h0, 3'd4, 8'd5));
    tbl.push_back(st(2'b01, WE, 2'd0, 2'b11, 2'd0, 80'h0, 3'd4, 8'd6));
    tbl.push_back(st(2'b01, WD, 2'd0, 2'b00, 2'd3, 80'h0, 3'd4, 8'd5));
    tbl.push_back(st(2'b10, '0, 2'd3, 2'b01, 2'd3, WD,    3'd4, 8'd1));
    tbl.push_back(st(2'b01, WA, 2'd0, 2'b00, 2'd0, WD,    3'd4, 8'd2));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      send(tbl[i].cmd, tbl[i].d, tbl[i].idx);
      checks++;
      e = exp_q.pop_front();
      if (timed_out) begin
        errors++;
        $display("FAIL dictionary[%0d] no response within bound", i);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL dictionary[%0d] got resp=%0d cout=%0d dout=%h fill=%0d lat=%0d want resp=%0d cout=%0d dout=%h fill=%0d lat=%0d",
                   i, o.resp, o.cout, o.dout, o.fill, o.lat, e.resp, e.cout, e.dout, e.fill, e.lat);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL full_flag got %b want 1", full);
    end
  endtask

  task automatic test_clear();
    stim_t tbl[$];
    rsp_t  e, o;
    do_reset();
    tbl.push_back(st(2'b01, WA, 2'd0, 2'b00, 2'd0, 80'h0, 3'd1, 8'd2));
    tbl.push_back(st(2'b01, WB, 2'd0, 2'b00, 2'd1, 80'h0, 3'd2, 8'd3));
    tbl.push_back(st(2'b01, WC, 2'd0, 2'b00, 2'd2, 80'h0, 3'd3, 8'd4));
    tbl.push_back(st(2'b10, '0, 2'd1, 2'b01, 2'd2, WB,    3'd3, 8'd1));
`ifdef CDU_DICT_CLEAR_EN
    tbl.push_back(st(2'b11, '0, 2'd0, 2'b10, 2'd2, WB,    3'd0, 8'd1));
    tbl.push_back(st(2'b10, '0, 2'd0, 2'b11, 2'd0, 80'h0, 3'd0, 8'd1));
`else
    tbl.push_back(st(2'b11, '0, 2'd0, 2'b11, 2'd0, 80'h0, 3'd3, 8'd1));
    tbl.push_back(st(2'b10, '0, 2'd0, 2'b01, 2'd0, WA,    3'd3, 8'd1));
`endif
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      send(tbl[i].cmd, tbl[i].d, tbl[i].idx);
      checks++;
      e = exp_q.pop_front();
      if (timed_out) begin
        errors++;
        $display("FAIL clear[%0d] no response within bound", i);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL clear[%0d] got resp=%0d cout=%0d dout=%h fill=%0d lat=%0d want resp=%0d cout=%0d dout=%h fill=%0d lat=%0d",
                   i, o.resp, o.cout, o.dout, o.fill, o.lat, e.resp, e.cout, e.dout, e.fill, e.lat);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t tbl[$];
    rsp_t  e, o;
    do_reset();
    tbl.push_back(st(2'b01, WA, 2'd0, 2'b00, 2'd0, 80'h0, 3'd1, 8'd2));
    tbl.push_back(st(2'b01, WB, 2'd0, 2'b00, 2'd1, 80'h0, 3'd2, 8'd3));
    tbl.push_back(st(2'b01, WC, 2'd0, 2'b00, 2'd2, 80'h0, 3'd3, 8'd4));
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i].e);
      send(tbl[i].cmd, tbl[i].d, tbl[i].idx);
      checks++;
      e = exp_q.pop_front();
      if (timed_out) begin
        errors++;
        $display("FAIL reset_mid_fill[%0d] no response within bound", i);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL reset_mid_fill[%0d] got resp=%0d cout=%0d fill=%0d lat=%0d want resp=%0d cout=%0d fill=%0d lat=%0d",
                   i, o.resp, o.cout, o.fill, o.lat, e.resp, e.cout, e.fill, e.lat);
        end
      end
    end
    // Miss on a 3-entry dictionary would respond in cycle 5; reset lands in cycle 2
    @(negedge clk);
    command = 2'b01;
    data_in = WE;
    @(posedge clk);
    #1;
    c0 = cyc;
    command = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (obs_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_resp got %0d responses want 0", obs_q.size());
      obs_q.delete();
    end
    checks++;
    if ({ready, fill_count, full, compressed_out, response} !== {1'b1, 3'd0, 1'b0, 2'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_state got rdy=%b fill=%0d full=%b cout=%0d resp=%0d want rdy=1 fill=0 full=0 cout=0 resp=0",
               ready, fill_count, full, compressed_out, response);
    end
    exp_q.push_back('{resp: 2'b11, cout: 2'd0, dout: 80'h0, fill: 3'd0, lat: 8'd1});
    send(2'b10, '0, 2'd0);
    checks++;
    e = exp_q.pop_front();
    if (timed_out) begin
      errors++;
      $display("FAIL reset_mid_decompress no response within bound");
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_decompress got resp=%0d fill=%0d lat=%0d want resp=%0d fill=%0d lat=%0d",
                 o.resp, o.fill, o.lat, e.resp, e.fill, e.lat);
      end
    end
  endtask

  task automatic test_ignored();
    rsp_t e, o;
    do_reset();
    exp_q.push_back('{resp: 2'b00, cout: 2'd0, dout: 80'h0, fill: 3'd1, lat: 8'd2});
    send(2'b01, WA, 2'd0);
    checks++;
    e = exp_q.pop_front();
    if (timed_out) begin
      errors++;
      $display("FAIL ignored_setup no response within bound");
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL ignored_setup got resp=%0d cout=%0d fill=%0d lat=%0d want resp=%0d cout=%0d fill=%0d lat=%0d",
                 o.resp, o.cout, o.fill, o.lat, e.resp, e.cout, e.fill, e.lat);
      end
    end
    @(negedge clk);
    exp_q.push_back('{resp: 2'b01, cout: 2'd0, dout: WA, fill: 3'd1, lat: 8'd1});
    command = 2'b10;
    compressed_in = 2'd0;
    @(posedge clk);
    #1;
    c0 = cyc;
    // COMPRESS presented only during the RESP cycle, where ready is low
    command = 2'b01;
    data_in = WB;
    @(posedge clk);
    #1;
    command = 2'b00;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    e = exp_q.pop_front();
    if (obs_q.size() !== 1) begin
      errors++;
      $display("FAIL ignored_count got %0d responses want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL ignored_decompress got resp=%0d dout=%h fill=%0d lat=%0d want resp=%0d dout=%h fill=%0d lat=%0d",
                 o.resp, o.dout, o.fill, o.lat, e.resp, e.dout, e.fill, e.lat);
      end
    end
    obs_q.delete();
    checks++;
    if (fill_count !== 3'd1) begin
      errors++;
      $display("FAIL ignored_fill got %0d want 1", fill_count);
    end
  endtask

  initial begin
    test_reset();
    test_dictionary();
    test_clear();
    test_reset_mid();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
